// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the arbiter state type used by ahb_master_arbiter.
package ahb_pkg;

  // AHB transfer type. Only IDLE and NONSEQ are ever driven by this master.
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Arbiter sequencing: pick a requester, drive its address phase, then its data phase.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first set request at or after ptr_i,
// wrapping modulo NUM_REQ. Returns both the one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan from the pointer upwards; the first hit wins and later hits are ignored.
  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        grant_o[cand]  = 1'b1;
        idx_o          = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB master port between NUM_REQ requesters. A round-robin pick in IDLE
// latches the winner's command, which then runs as one SINGLE NONSEQ transfer
// (address phase, data phase, wait states from Hreadyout). The response is routed
// back to the owning requester as a one-cycle rsp_valid pulse.
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int         NUM_REQ   = 4,
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter logic [2:0] HSIZE_VAL = 3'b010
) (
  input  logic                      Hclk,
  input  logic                      Hreset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         Haddr,
  output logic                      Hwrite,
  output logic [1:0]                Htrans,
  output logic [2:0]                Hsize,
  output logic [2:0]                Hburst,
  output logic [DATA_W-1:0]         Hwdata,
  output logic                      Hreadyin,
  input  logic                      Hreadyout,
  input  logic [1:0]                Hresp,
  input  logic [DATA_W-1:0]         Hrdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Sequencing state and round-robin pointer.
  arb_state_t          state_q,     state_d;
  logic [IDX_W-1:0]    ptr_q,       ptr_d;

  // Latched command of the requester that owns the current transfer.
  logic [IDX_W-1:0]    gidx_q,      gidx_d;
  logic [NUM_REQ-1:0]  gnt_q,       gnt_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;

  // Registered bus and requester-facing outputs.
  logic [ADDR_W-1:0]   haddr_q,     haddr_d;
  logic                hwrite_q,    hwrite_d;
  htrans_t             htrans_q,    htrans_d;
  logic [DATA_W-1:0]   hwdata_q,    hwdata_d;
  logic                hreadyin_q,  hreadyin_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q,   rsp_err_d;

  // Round-robin pick over the live requests.
  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_any)
  );

  // Next-state and next-output logic; everything holds unless a state acts on it,
  // and the one-cycle pulses clear by default.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    gnt_d       = gnt_q;
    wdata_d     = wdata_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    htrans_d    = htrans_q;
    hwdata_d    = hwdata_q;
    hreadyin_d  = 1'b1;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        htrans_d = HTRANS_IDLE;
        if (arb_any) begin
          gidx_d      = arb_idx;
          gnt_d       = arb_grant;
          haddr_d     = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
          hwrite_d    = req_write[arb_idx];
          wdata_d     = req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
          req_ready_d = arb_grant;
          htrans_d    = HTRANS_NONSEQ;
          state_d     = ST_ADDR;
        end
      end

      // Address phase: bus signals are held as-is while the bridge stalls.
      ST_ADDR: begin
        if (Hreadyout) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = hwrite_q ? wdata_q : '0;
          state_d  = ST_DATA;
        end
      end

      // Data phase: Hwdata is held through wait states; completion frees the bus
      // and moves the pointer just past the requester that was served.
      ST_DATA: begin
        if (Hreadyout) begin
          rsp_rdata_d = Hrdata;
          rsp_err_d   = (Hresp == HRESP_ERROR);
          rsp_valid_d = gnt_q;
          ptr_d       = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        htrans_d = HTRANS_IDLE;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; a reset mid-transfer drops it.
  always_ff @(posedge Hclk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values,
    // independent of statement order.
    if (Hreset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      gnt_q       <= '0;
      wdata_q     <= '0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      hwdata_q    <= '0;
      hreadyin_q  <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      gnt_q       <= gnt_d;
      wdata_q     <= wdata_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      htrans_q    <= htrans_d;
      hwdata_q    <= hwdata_d;
      hreadyin_q  <= hreadyin_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign Haddr     = haddr_q;
  assign Hwrite    = hwrite_q;
  assign Htrans    = htrans_q;
  assign Hwdata    = hwdata_q;
  assign Hreadyin  = hreadyin_q;

  // Size and burst never change, so they are tied straight to their constants.
  assign Hsize     = HSIZE_VAL;
  assign Hburst    = HBURST_SINGLE;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Self-checking bench for ahb_master_arbiter: reset values, a table of single
// transfers, hand-written rotation and reset-abort sequences, then randomized
// traffic against a transaction-level model.
module tb_ahb_master_arbiter;

  localparam int N        = 4;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int RAND_CYC = 900;

  logic            Hclk;
  logic            Hreset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   Haddr;
  logic            Hwrite;
  logic [1:0]      Htrans;
  logic [2:0]      Hsize;
  logic [2:0]      Hburst;
  logic [DW-1:0]   Hwdata;
  logic            Hreadyin;
  logic            Hreadyout;
  logic [1:0]      Hresp;
  logic [DW-1:0]   Hrdata;

  int n_checks = 0;
  int n_pass   = 0;

  ahb_master_arbiter dut (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .Haddr     (Haddr),
    .Hwrite    (Hwrite),
    .Htrans    (Htrans),
    .Hsize     (Hsize),
    .Hburst    (Hburst),
    .Hwdata    (Hwdata),
    .Hreadyin  (Hreadyin),
    .Hreadyout (Hreadyout),
    .Hresp     (Hresp),
    .Hrdata    (Hrdata)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, got timeout, required $finish");
    $fatal(1);
  end

  // Single-transfer vectors: stimulus plus the independently worked-out outcome.
  typedef struct {
    int          req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_a;
    int          wait_d;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_rsp;
    int          exp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  // Round-robin rotation capture.
  int got_cyc[$];
  int got_idx[$];

  // Random-phase model state.
  int          m_ptr;
  bit          busy;
  bit          in_data;
  bit          completing;
  bit          accepting;
  int          eg;
  int          rate;
  int          t_g;
  logic        t_wr;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [31:0] exp_rd;
  logic        exp_er;
  logic [31:0] last_rdata;
  logic        last_err;
  logic [N-1:0] exp_oh;
  logic [N-1:0] rsp_oh;
  int          n_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic do_reset();
    Hreset    = 1'b1;
    req_valid = '0;
    Hreadyout = 1'b1;
    Hresp     = 2'b00;
    tick();
    tick();
    Hreset    = 1'b0;
  endtask

  // Spec rule: among valid requesters, the winner is the one at the smallest
  // forward distance from the pointer.
  function automatic int ref_grant(input logic [N-1:0] v, input int p);
    int best;
    int bestd;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i] && (((i - p + N) % N) < bestd)) begin
        bestd = (i - p + N) % N;
        best  = i;
      end
    end
    return best;
  endfunction

  function automatic int lowest_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic run_vec(input vec_t v);
    int seen;
    int last_c;
    seen   = -1;
    last_c = v.wait_a + 2 + v.wait_d;
    req_valid               = '0;
    req_valid[v.req]        = 1'b1;
    req_write[v.req]        = v.wr;
    req_addr[v.req*AW +: AW]  = v.addr;
    req_wdata[v.req*DW +: DW] = v.wdata;
    Hreadyout = 1'b1;
    Hresp     = 2'b00;
    Hrdata    = 32'h5A5A_5A5A;
    for (int cyc = 1; cyc <= 15 && seen < 0; cyc++) begin
      tick();
      req_valid = '0;
      if (cyc == 1) check("vec_req_ready", req_ready, v.exp_ready);
      else          check("vec_req_ready_once", req_ready, '0);
      if (cyc <= v.wait_a + 1) begin
        check("vec_htrans_addr", Htrans, 2'b10);
        check("vec_haddr", Haddr, v.addr);
        check("vec_hwrite", Hwrite, v.wr);
      end else if (cyc <= last_c) begin
        check("vec_htrans_data", Htrans, 2'b00);
        check("vec_hwdata", Hwdata, v.wr ? v.wdata : 32'h0);
      end
      if (rsp_valid != '0) begin
        seen = cyc;
        check("vec_rsp_valid", rsp_valid, v.exp_rsp);
        check("vec_rsp_rdata", rsp_rdata, v.exp_rdata);
        check("vec_rsp_err", rsp_err, v.exp_err);
      end
      Hreadyout = (cyc == v.wait_a + 1) || (cyc == last_c);
      if (cyc == last_c) begin
        Hrdata = v.rdata;
        Hresp  = v.resp;
      end else begin
        Hrdata = 32'h5A5A_5A5A;
        Hresp  = 2'b00;
      end
    end
    check("vec_rsp_cycle", seen, v.exp_cyc);
    Hreadyout = 1'b1;
    Hresp     = 2'b00;
  endtask

  initial begin
    Hreset    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    Hreadyout = 1'b1;
    Hresp     = 2'b00;
    Hrdata    = '0;

    //                req wr    addr          wdata         wa wd rdata         resp   rdy      rsp      cyc exp_rdata     err
    vecs[0] = '{0, 1'b1, 32'h8000_0001, 32'h0000_00A3, 0, 0, 32'h0000_0000, 2'b00, 4'b0001, 4'b0001, 3, 32'h0000_0000, 1'b0};
    vecs[1] = '{2, 1'b0, 32'h8000_00A2, 32'h1357_9BDF, 0, 2, 32'hDEAD_BEEF, 2'b00, 4'b0100, 4'b0100, 5, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1, 1'b1, 32'h8000_0010, 32'h1234_5678, 0, 0, 32'h0000_0000, 2'b01, 4'b0010, 4'b0010, 3, 32'h0000_0000, 1'b1};
    vecs[3] = '{3, 1'b0, 32'h8000_0020, 32'h0000_0000, 1, 0, 32'hCAFE_F00D, 2'b00, 4'b1000, 4'b1000, 4, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1, 1'b1, 32'h8000_0044, 32'h0F0F_0F0F, 4, 0, 32'h1111_2222, 2'b00, 4'b0010, 4'b0010, 7, 32'h1111_2222, 1'b0};
    vecs[5] = '{0, 1'b0, 32'h8000_0300, 32'hFFFF_FFFF, 1, 1, 32'h0000_0001, 2'b00, 4'b0001, 4'b0001, 5, 32'h0000_0001, 1'b0};

    // Reset values while Hreset is held.
    tick();
    tick();
    check("rst_htrans", Htrans, 2'b00);
    check("rst_haddr", Haddr, 32'h0);
    check("rst_hwrite", Hwrite, 1'b0);
    check("rst_hwdata", Hwdata, 32'h0);
    check("rst_hsize", Hsize, 3'b010);
    check("rst_hburst", Hburst, 3'b000);
    check("rst_hreadyin", Hreadyin, 1'b0);
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_rsp_valid", rsp_valid, 4'b0000);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    Hreset = 1'b0;
    tick();
    check("post_rst_hreadyin", Hreadyin, 1'b1);
    check("post_rst_htrans", Htrans, 2'b00);

    // Table of single transfers, back to back.
    for (int k = 0; k < 6; k++) run_vec(vecs[k]);
    Hrdata = 32'h7777_7777;
    tick();
    tick();
    check("rdata_hold", rsp_rdata, vecs[5].exp_rdata);
    check("idle_hburst", Hburst, 3'b000);

    // All requesters valid continuously: strict rotation, one grant per 3 cycles.
    do_reset();
    req_write = 4'b0101;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = 32'h9000_0000 + 32'(i);
      req_wdata[i*DW +: DW] = 32'hA000_0000 + 32'(i);
    end
    req_valid = 4'b1111;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      tick();
      if (req_ready != '0) begin
        got_cyc.push_back(cyc);
        got_idx.push_back(lowest_set(req_ready));
        check("rr_onehot", $countones(req_ready), 1);
      end
    end
    req_valid = '0;
    check("rr_count", got_cyc.size(), 5);
    for (int k = 0; k < 5 && k < got_cyc.size(); k++) begin
      check("rr_index", got_idx[k], k % N);
      check("rr_cycle", got_cyc[k], 1 + 3 * k);
    end
    repeat (4) tick();

    // Reset during a data phase drops the transfer and rewinds the pointer.
    do_reset();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    tick();
    check("abort_pre_rsp", rsp_valid, 4'b0010);
    tick();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    check("abort_in_data", Htrans, 2'b00);
    Hreset = 1'b1;
    tick();
    check("abort_htrans", Htrans, 2'b00);
    check("abort_no_rsp", rsp_valid, 4'b0000);
    check("abort_no_ready", req_ready, 4'b0000);
    Hreset    = 1'b0;
    req_valid = 4'b1010;
    tick();
    check("abort_regrant_lowest", req_ready, 4'b0010);
    check("abort_no_rsp_after", rsp_valid, 4'b0000);
    req_valid = '0;
    repeat (4) tick();

    // Randomized traffic against a transaction-level model.
    do_reset();
    m_ptr      = 0;
    busy       = 1'b0;
    in_data    = 1'b0;
    last_rdata = '0;
    last_err   = 1'b0;
    n_done     = 0;
    t_g        = 0;
    for (int cyc = 0; cyc < RAND_CYC; cyc++) begin
      case ((cyc / 150) % 3)
        0:       rate = 1;
        1:       rate = 6;
        default: rate = 30;
      endcase
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, rate) == 0) begin
            req_valid[i]          = 1'b1;
            req_write[i]          = 1'($urandom_range(0, 1));
            req_addr[i*AW +: AW]  = $urandom;
            req_wdata[i*DW +: DW] = $urandom;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          req_write[i]          = ~req_write[i];
          req_addr[i*AW +: AW]  = $urandom;
          req_wdata[i*DW +: DW] = $urandom;
        end
      end
      Hreadyout = ($urandom_range(0, 3) != 0);
      Hrdata    = $urandom;
      Hresp     = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;

      eg         = busy ? -1 : ref_grant(req_valid, m_ptr);
      completing = busy && in_data && Hreadyout;
      accepting  = busy && !in_data && Hreadyout;
      exp_rd     = Hrdata;
      exp_er     = (Hresp == 2'b01);
      exp_oh     = '0;
      if (eg >= 0) begin
        exp_oh[eg] = 1'b1;
        t_g        = eg;
        t_wr       = req_write[eg];
        t_addr     = req_addr[eg*AW +: AW];
        t_wdata    = req_wdata[eg*DW +: DW];
      end

      tick();

      check("rnd_req_ready", req_ready, exp_oh);
      if (eg >= 0) begin
        busy          = 1'b1;
        in_data       = 1'b0;
        req_valid[eg] = 1'b0;
      end
      if (completing) begin
        rsp_oh      = '0;
        rsp_oh[t_g] = 1'b1;
        check("rnd_rsp_valid", rsp_valid, rsp_oh);
        check("rnd_rsp_rdata", rsp_rdata, exp_rd);
        check("rnd_rsp_err", rsp_err, exp_er);
        last_rdata = exp_rd;
        last_err   = exp_er;
        busy       = 1'b0;
        in_data    = 1'b0;
        m_ptr      = (t_g + 1) % N;
        n_done++;
      end else begin
        check("rnd_rsp_quiet", rsp_valid, '0);
        check("rnd_rdata_hold", rsp_rdata, last_rdata);
        check("rnd_err_hold", rsp_err, last_err);
      end
      if (accepting) in_data = 1'b1;
      if (busy && !in_data) begin
        check("rnd_htrans_nonseq", Htrans, 2'b10);
        check("rnd_haddr", Haddr, t_addr);
        check("rnd_hwrite", Hwrite, t_wr);
      end else begin
        check("rnd_htrans_idle", Htrans, 2'b00);
      end
      if (busy && in_data) check("rnd_hwdata", Hwdata, t_wr ? t_wdata : 32'h0);
      check("rnd_hreadyin", Hreadyin, 1'b1);
    end
    check("rnd_made_progress", n_done > 50, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
